// File: rtl/display_pkg.sv
// Shared types and constants for the two-source 7-segment display arbiter:
// FSM encodings, BCD word layout and the segment decode table.
package display_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  // Segment patterns {DP,G,F,E,D,C,B,A}, active-high, DP never lit.
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;

  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_e;

  typedef logic [3:0]                  bcd_digit_t;
  typedef logic [NUM_DIGITS-1:0][3:0]  bcd_word_t;

  function automatic logic [7:0] seg_decode(input bcd_digit_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction applied to each digit before every shift.
  function automatic bcd_digit_t dd_adjust(input bcd_digit_t d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_serial.sv
// Serial double-dabble converter: 10-bit binary to four BCD digits in a fixed
// 10 shift cycles; done pulses during the last shift, start while busy is ignored.
module bcd_serial
  import display_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [9:0] bin_i,
  output logic       done_o,
  output bcd_word_t  bcd_o
);

  localparam logic [3:0] SHIFT_LAST = 4'd9;

  logic [9:0] bin_q, bin_d;
  bcd_word_t  bcd_q, bcd_d;
  bcd_word_t  adj;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    adj    = bcd_q;
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      adj[k] = dd_adjust(bcd_q[k]);
    end
    if (busy_q) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d          = cnt_q + 4'd1;
      if (cnt_q == SHIFT_LAST) begin
        busy_d = 1'b0;
      end
    end else if (start_i) begin
      bin_d  = bin_i;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done_o = busy_q && (cnt_q == SHIFT_LAST);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/display_arbiter_ctrl.sv
// Round-robin owner of a 4-digit multiplexed 7-segment display shared by two
// 10-bit sources, with minimum hold time, double-buffered digits and blanking.
module display_arbiter_ctrl
  import display_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 12_000_000,
  parameter int unsigned SCAN_BITS    = 10,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter bit          LZ_SUPPRESS  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [9:0] val_a,
  input  logic       req_b,
  input  logic [9:0] val_b,
  output logic [1:0] gnt,
  output logic       busy,
  output logic [7:0] seg,
  output logic [5:0] hex
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam int unsigned SLOT_W = SCAN_BITS - 2;
  localparam logic [SLOT_W-1:0]    BLANK_LIM = SLOT_W'(BLANK_CYCLES);

  logic [2:0]           state_q, state_d;
  logic [1:0]           gnt_q, gnt_d;
  owner_e               rr_q, rr_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  bcd_word_t            disp_q, disp_d;
  logic [SCAN_BITS-1:0] scan_q;
  logic [7:0]           seg_q, seg_d;
  logic [5:0]           hex_q, hex_d;

  logic       cvt_start;
  logic       cvt_done;
  logic [9:0] cvt_bin;
  bcd_word_t  cvt_bcd;
  logic       own_req;
  logic       other_req;

  assign own_req   = gnt_q[1] ? req_b : req_a;
  assign other_req = gnt_q[1] ? req_a : req_b;
  assign cvt_bin   = gnt_q[1] ? val_b : val_a;

  bcd_serial u_bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (cvt_start),
    .bin_i   (cvt_bin),
    .done_o  (cvt_done),
    .bcd_o   (cvt_bcd)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    hold_d    = hold_q;
    disp_d    = disp_q;
    cvt_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_a || req_b) begin
          state_d = ST_LOAD;
          if (req_a && req_b) begin
            gnt_d = (rr_q == OWN_A) ? 2'b01 : 2'b10;
            rr_d  = (rr_q == OWN_A) ? OWN_B : OWN_A;
          end else begin
            gnt_d = req_a ? 2'b01 : 2'b10;
          end
        end
      end
      ST_LOAD: begin
        cvt_start = 1'b1;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cvt_done) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        disp_d  = cvt_bcd;
        hold_d  = '0;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_W'(1);
        end else if (other_req) begin
          // Switching owner: the pointer now favours the one just released.
          gnt_d   = ~gnt_q;
          rr_d    = gnt_q[1] ? OWN_B : OWN_A;
          state_d = ST_LOAD;
        end else if (own_req) begin
          state_d = ST_LOAD;
        end else begin
          gnt_d   = 2'b00;
          state_d = ST_IDLE;
        end
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  logic [1:0]            idx;
  logic [SLOT_W-1:0]     slot_lo;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;

  assign idx     = scan_q[SCAN_BITS-1 -: 2];
  assign slot_lo = scan_q[SLOT_W-1:0];

  // A digit is suppressed only when it and every more significant digit are zero.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run && (disp_q[k] == 4'd0);
      lz_mask[k] = zero_run && LZ_SUPPRESS;
    end
  end

  always_comb begin
    seg_d = lz_mask[idx] ? SEG_BLANK : seg_decode(disp_q[idx]);
    hex_d = 6'h3F;
    if (slot_lo >= BLANK_LIM) begin
      hex_d[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      rr_q    <= OWN_A;
      hold_q  <= '0;
      disp_q  <= '0;
      scan_q  <= '0;
      seg_q   <= SEG_BLANK;
      hex_q   <= 6'h3F;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      disp_q  <= disp_d;
      scan_q  <= scan_q + SCAN_BITS'(1);
      seg_q   <= seg_d;
      hex_q   <= hex_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign seg  = seg_q;
  assign hex  = hex_q;

endmodule
